// File: rtl/lt24_pkg.sv
// rtl/lt24_pkg.sv - shared opcodes, sprite geometry, limits and state enums for the LT24 sprite streamer
package lt24_pkg;
    localparam logic [7:0]  OP_CASET = 8'h2A;
    localparam logic [7:0]  OP_PASET = 8'h2B;
    localparam logic [7:0]  OP_RAMWR = 8'h2C;
    localparam int          SPRITE_W = 64;
    localparam int          SPRITE_H = 64;
    localparam logic [8:0]  X_MAX    = 9'd176;
    localparam logic [8:0]  Y_MAX    = 9'd256;
    localparam logic [11:0] PIX_LAST = 12'd4095;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CASET, ST_PASET, ST_RAMWR, ST_PIXELS, ST_FINISH
    } pic_state_t;

    typedef enum logic [1:0] {
        WR_IDLE, WR_SETUP, WR_LOW, WR_HIGH
    } wr_state_t;

    // Window parameter byte: idx 1..4 = start hi, start lo, end hi, end lo
    function automatic logic [15:0] window_byte(input logic [2:0] idx, input logic [8:0] origin,
                                                input int span);
        logic [15:0] s;
        logic [15:0] e;
        s = {7'd0, origin};
        e = s + 16'(span - 1);
        case (idx)
            3'd1:    window_byte = {8'd0, s[15:8]};
            3'd2:    window_byte = {8'd0, s[7:0]};
            3'd3:    window_byte = {8'd0, e[15:8]};
            default: window_byte = {8'd0, e[7:0]};
        endcase
    endfunction
endpackage

// File: rtl/lt24_pic_streamer_if.sv
// rtl/lt24_pic_streamer_if.sv - req/ack handshake between the streamer sequencer and the 8080 bus writer
interface lt24_pic_streamer_if;
    logic        req;
    logic        req_rs;
    logic [15:0] req_data;
    logic        ready;
    logic        ack;
    logic        low_start;

    modport master (output req, req_rs, req_data, input ready, ack, low_start);
    modport slave  (input req, req_rs, req_data, output ready, ack, low_start);
endinterface

// File: rtl/lt24_bus_writer.sv
// rtl/lt24_bus_writer.sv - one 8080 write cycle per accepted request: SETUP, LOW, HIGH
module lt24_bus_writer
    import lt24_pkg::*;
#(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    lt24_pic_streamer_if.slave hs,
    output logic              lcd_rs,
    output logic [15:0]       lcd_data,
    output logic              lcd_wr_n
);
    localparam logic [3:0] LOW_LOAD  = 4'(WR_LOW_CYC - 1);
    localparam logic [3:0] HIGH_LOAD = 4'(WR_HIGH_CYC - 1);

    wr_state_t  state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       take;

    // The last HIGH cycle doubles as an idle slot so back-to-back writes have no gap
    assign hs.ack       = (state == WR_HIGH) && (cnt == 4'd0);
    assign hs.ready     = (state == WR_IDLE) || hs.ack;
    assign hs.low_start = (state == WR_LOW) && (cnt == LOW_LOAD);
    assign take         = hs.req && hs.ready;
    assign lcd_wr_n     = (state != WR_LOW);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            WR_IDLE: begin
                if (take) state_nxt = WR_SETUP;
            end
            WR_SETUP: begin
                state_nxt = WR_LOW;
                cnt_nxt   = LOW_LOAD;
            end
            WR_LOW: begin
                if (cnt == 4'd0) begin
                    state_nxt = WR_HIGH;
                    cnt_nxt   = HIGH_LOAD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WR_HIGH: begin
                if (cnt == 4'd0) state_nxt = take ? WR_SETUP : WR_IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= WR_IDLE;
            cnt      <= 4'd0;
            lcd_rs   <= 1'b0;
            lcd_data <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (take) begin
                lcd_rs   <= hs.req_rs;
                lcd_data <= hs.req_data;
            end
        end
    end
endmodule

// File: rtl/lt24_pic_streamer.sv
// rtl/lt24_pic_streamer.sv - streams one 64x64 sprite from pic_mem to the LT24 over an 8080 write bus
module lt24_pic_streamer
    import lt24_pkg::*;
#(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [8:0]  x_pos,
    input  logic [8:0]  y_pos,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] mem_address,
    output logic        mem_chipselect,
    output logic        mem_clken,
    output logic        mem_write,
    output logic [15:0] mem_writedata,
    output logic [1:0]  mem_byteenable,
    input  logic [15:0] mem_readdata,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_rd_n,
    output logic        lcd_wr_n,
    output logic [15:0] lcd_data,
    output logic        lcd_own
);
    lt24_pic_streamer_if hs ();

    pic_state_t  state, state_nxt;
    logic [2:0]  sub, sub_nxt;
    logic [11:0] pix_cnt, pix_cnt_nxt;
    logic        all_sent, all_sent_nxt;
    logic [8:0]  x_q, y_q;
    logic        rd_pending;
    logic [15:0] pix_hold, pix_word;
    logic        take, in_range, start_ok, start_bad;

    assign in_range  = (x_pos <= X_MAX) && (y_pos <= Y_MAX);
    assign start_ok  = start && (state == ST_IDLE) && in_range;
    assign start_bad = start && (state == ST_IDLE) && !in_range;
    assign take      = hs.req && hs.ready;

    // Bypass covers WR_LOW_CYC=WR_HIGH_CYC=1, where read data lands in the accepting cycle
    assign pix_word = rd_pending ? mem_readdata : pix_hold;

    // pix_cnt already points at the pixel after the one being written
    assign mem_chipselect = (state == ST_PIXELS) && hs.low_start && !all_sent;
    assign mem_clken      = mem_chipselect;
    assign mem_address    = pix_cnt;
    assign mem_write      = 1'b0;
    assign mem_writedata  = 16'd0;
    assign mem_byteenable = 2'b11;
    assign lcd_rd_n       = 1'b1;
    assign lcd_own        = busy;
    assign lcd_cs_n       = !busy;

    always_comb begin
        state_nxt    = state;
        sub_nxt      = sub;
        pix_cnt_nxt  = pix_cnt;
        all_sent_nxt = all_sent;
        hs.req       = 1'b0;
        hs.req_rs    = 1'b1;
        hs.req_data  = 16'd0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt    = ST_CASET;
                    sub_nxt      = 3'd0;
                    pix_cnt_nxt  = 12'd0;
                    all_sent_nxt = 1'b0;
                end
            end
            ST_CASET, ST_PASET: begin
                busy      = 1'b1;
                hs.req    = 1'b1;
                hs.req_rs = (sub != 3'd0);
                if (sub == 3'd0)
                    hs.req_data = {8'd0, ((state == ST_CASET) ? OP_CASET : OP_PASET)};
                else if (state == ST_CASET)
                    hs.req_data = window_byte(sub, x_q, SPRITE_W);
                else
                    hs.req_data = window_byte(sub, y_q, SPRITE_H);
                if (take) begin
                    if (sub == 3'd4) begin
                        sub_nxt   = 3'd0;
                        state_nxt = (state == ST_CASET) ? ST_PASET : ST_RAMWR;
                    end else begin
                        sub_nxt = sub + 3'd1;
                    end
                end
            end
            ST_RAMWR: begin
                busy        = 1'b1;
                hs.req      = 1'b1;
                hs.req_rs   = 1'b0;
                hs.req_data = {8'd0, OP_RAMWR};
                if (take) state_nxt = ST_PIXELS;
            end
            ST_PIXELS: begin
                busy        = 1'b1;
                hs.req      = !all_sent;
                hs.req_data = pix_word;
                if (take) begin
                    if (pix_cnt == PIX_LAST) all_sent_nxt = 1'b1;
                    else                     pix_cnt_nxt  = pix_cnt + 12'd1;
                end
                if (all_sent && hs.ack) state_nxt = ST_FINISH;
            end
            ST_FINISH: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            sub        <= 3'd0;
            pix_cnt    <= 12'd0;
            all_sent   <= 1'b0;
            x_q        <= 9'd0;
            y_q        <= 9'd0;
            err        <= 1'b0;
            rd_pending <= 1'b0;
            pix_hold   <= 16'd0;
        end else begin
            state      <= state_nxt;
            sub        <= sub_nxt;
            pix_cnt    <= pix_cnt_nxt;
            all_sent   <= all_sent_nxt;
            err        <= start_bad;
            rd_pending <= mem_chipselect;
            if (start_ok) begin
                x_q <= x_pos;
                y_q <= y_pos;
            end
            if (rd_pending) pix_hold <= mem_readdata;
        end
    end

    lt24_bus_writer #(
        .WR_LOW_CYC (WR_LOW_CYC),
        .WR_HIGH_CYC(WR_HIGH_CYC)
    ) u_writer (
        .clk     (clk),
        .reset_n (reset_n),
        .hs      (hs),
        .lcd_rs  (lcd_rs),
        .lcd_data(lcd_data),
        .lcd_wr_n(lcd_wr_n)
    );
endmodule

// File: tb/tb_lt24_pic_streamer.sv
// tb/tb_lt24_pic_streamer.sv - self-checking bench: scoreboarded LCD writes, pic_mem model, corner sequences
`timescale 1ns/1ps
module tb_lt24_pic_streamer;
    import lt24_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, start;
    logic [8:0]  x_pos, y_pos;
    logic        busy, done, err;
    logic [11:0] mem_address;
    logic        mem_chipselect, mem_clken, mem_write;
    logic [15:0] mem_writedata;
    logic [1:0]  mem_byteenable;
    logic [15:0] mem_readdata = 16'd0;
    logic        lcd_cs_n, lcd_rs, lcd_rd_n, lcd_wr_n, lcd_own;
    logic [15:0] lcd_data;

    logic        ut_rs, ut_wr_n;
    logic [15:0] ut_data;

    typedef struct {
        logic [8:0] x;
        logic [8:0] y;
        logic       exp_err;
        logic       exp_busy;
    } vec_t;
    vec_t tbl [6];

    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0;
    logic [16:0] exp_q [$];
    int          fall_cnt = 0, rise_cnt = 0, rd_cnt = 0, done_cnt = 0, last_fall = -1;
    logic [11:0] rd_expect = 12'd0;
    logic [16:0] cur_word, prev_word = 17'd0, fall_word = 17'd0, exp_w;
    logic        prev_wr_n = 1'b1;
    int          t_start, t_done;

    always #5 clk = ~clk;

    lt24_pic_streamer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .x_pos(x_pos), .y_pos(y_pos),
        .busy(busy), .done(done), .err(err),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata),
        .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_rd_n(lcd_rd_n), .lcd_wr_n(lcd_wr_n),
        .lcd_data(lcd_data), .lcd_own(lcd_own)
    );

    lt24_pic_streamer_if ut_hs ();
    lt24_bus_writer #(.WR_LOW_CYC(1), .WR_HIGH_CYC(1)) u_ut (
        .clk(clk), .reset_n(reset_n), .hs(ut_hs),
        .lcd_rs(ut_rs), .lcd_data(ut_data), .lcd_wr_n(ut_wr_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // pic_mem s2 model: read latency 1, contents mem[i] = i ^ 16'hA5A5
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_chipselect && mem_clken) mem_readdata <= {4'd0, mem_address} ^ 16'hA5A5;
    end

    always @(negedge clk) begin
        cur_word = {lcd_rs, lcd_data};
        if (done) done_cnt++;
        if (reset_n) begin
            if (mem_chipselect) begin
                chk("mem_clken", {31'd0, mem_clken}, 32'd1);
                chk("mem_addr_order", {20'd0, mem_address}, {20'd0, rd_expect});
                rd_expect++;
                rd_cnt++;
            end
            if (prev_wr_n && !lcd_wr_n) begin
                chk("setup_to_low_stable", {15'd0, cur_word}, {15'd0, prev_word});
                if (last_fall >= 0) chk("write_period", cyc - last_fall, 32'd5);
                last_fall = cyc;
                fall_word = cur_word;
                fall_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got 0x%0h want none", cur_word);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("lcd_word", {15'd0, cur_word}, {15'd0, exp_w});
                end
            end
            if (!prev_wr_n && lcd_wr_n) begin
                chk("low_to_high_stable", {15'd0, cur_word}, {15'd0, fall_word});
                rise_cnt++;
            end
        end
        prev_wr_n = lcd_wr_n;
        prev_word = cur_word;
    end

    task automatic check_reset_outputs();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_lcd_own", {31'd0, lcd_own}, 0);
        chk("rst_lcd_cs_n", {31'd0, lcd_cs_n}, 1);
        chk("rst_lcd_wr_n", {31'd0, lcd_wr_n}, 1);
        chk("rst_lcd_rs", {31'd0, lcd_rs}, 0);
        chk("rst_lcd_data", {16'd0, lcd_data}, 0);
        chk("rst_mem_address", {20'd0, mem_address}, 0);
        chk("rst_mem_cs", {31'd0, mem_chipselect}, 0);
        chk("rst_mem_clken", {31'd0, mem_clken}, 0);
    endtask

    task automatic begin_transfer(input logic [8:0] x, input logic [8:0] y);
        logic [15:0] xs, xe, ys, ye;
        xs = {7'd0, x};
        xe = xs + 16'd63;
        ys = {7'd0, y};
        ye = ys + 16'd63;
        exp_q.delete();
        exp_q.push_back({1'b0, 16'h002A});
        exp_q.push_back({9'h100, xs[15:8]});
        exp_q.push_back({9'h100, xs[7:0]});
        exp_q.push_back({9'h100, xe[15:8]});
        exp_q.push_back({9'h100, xe[7:0]});
        exp_q.push_back({1'b0, 16'h002B});
        exp_q.push_back({9'h100, ys[15:8]});
        exp_q.push_back({9'h100, ys[7:0]});
        exp_q.push_back({9'h100, ye[15:8]});
        exp_q.push_back({9'h100, ye[7:0]});
        exp_q.push_back({1'b0, 16'h002C});
        for (int i = 0; i < 4096; i++) exp_q.push_back({1'b1, 16'(i) ^ 16'hA5A5});
        fall_cnt  = 0;
        rise_cnt  = 0;
        rd_cnt    = 0;
        done_cnt  = 0;
        rd_expect = 12'd0;
        last_fall = -1;
        x_pos     = x;
        y_pos     = y;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        t_start = cyc;
        chk("accept_busy", {31'd0, busy}, 1);
        chk("accept_cs_n", {31'd0, lcd_cs_n}, 0);
    endtask

    task automatic wait_falls(input int n);
        int k;
        k = 0;
        while (fall_cnt < n && k < 25000) begin
            @(negedge clk);
            k++;
        end
        if (fall_cnt < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_falls_timeout: got %0d want %0d", fall_cnt, n);
        end
    endtask

    task automatic finish_checks();
        int k;
        k = 0;
        while (!done && k < 21000) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got 0 want 1");
        end else begin
            t_done = cyc;
            chk("done_latency_in_window",
                {31'd0, (t_done - t_start >= 20533) && (t_done - t_start <= 20537)}, 1);
            chk("rises_at_done", rise_cnt, 4107);
            chk("queue_drained", exp_q.size(), 0);
            chk("mem_reads", rd_cnt, 4096);
            chk("busy_with_done", {31'd0, busy}, 0);
            chk("cs_n_with_done", {31'd0, lcd_cs_n}, 1);
            chk("own_with_done", {31'd0, lcd_own}, 0);
        end
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        tbl[0] = '{9'd177, 9'd0,   1'b1, 1'b0};
        tbl[1] = '{9'd0,   9'd257, 1'b1, 1'b0};
        tbl[2] = '{9'd300, 9'd300, 1'b1, 1'b0};
        tbl[3] = '{9'd177, 9'd256, 1'b1, 1'b0};
        tbl[4] = '{9'd0,   9'd0,   1'b0, 1'b1};
        tbl[5] = '{9'd176, 9'd256, 1'b0, 1'b1};

        reset_n = 1'b0;
        start = 1'b0;
        x_pos = 9'd0;
        y_pos = 9'd0;
        ut_hs.req = 1'b0;
        ut_hs.req_rs = 1'b0;
        ut_hs.req_data = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        chk("tie_mem_write", {31'd0, mem_write}, 0);
        chk("tie_mem_writedata", {16'd0, mem_writedata}, 0);
        chk("tie_mem_byteenable", {30'd0, mem_byteenable}, 3);
        chk("tie_lcd_rd_n", {31'd0, lcd_rd_n}, 1);
        reset_n = 1'b1;

        // Bus writer handshake with 1-cycle LOW/HIGH, including a back-to-back request
        @(posedge clk); #1;
        chk("ut_idle_ready", {31'd0, ut_hs.ready}, 1);
        ut_hs.req = 1'b1; ut_hs.req_rs = 1'b1; ut_hs.req_data = 16'h1234;
        @(posedge clk); #1;
        chk("ut_setup_wr_n", {31'd0, ut_wr_n}, 1);
        chk("ut_setup_data", {15'd0, ut_rs, ut_data}, 32'h11234);
        chk("ut_setup_ready", {31'd0, ut_hs.ready}, 0);
        ut_hs.req_rs = 1'b0; ut_hs.req_data = 16'h5678;
        @(posedge clk); #1;
        chk("ut_low_wr_n", {31'd0, ut_wr_n}, 0);
        chk("ut_low_start", {31'd0, ut_hs.low_start}, 1);
        chk("ut_low_data", {16'd0, ut_data}, 32'h1234);
        @(posedge clk); #1;
        chk("ut_high_ack", {30'd0, ut_hs.ack, ut_wr_n}, 3);
        @(posedge clk); #1;
        chk("ut_b2b_setup", {14'd0, ut_hs.ack, ut_rs, ut_data}, 32'h05678);
        ut_hs.req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ut_back_idle", {29'd0, ut_hs.ready, ut_hs.ack, ut_wr_n}, 3'b101);

        for (int i = 0; i < 6; i++) begin
            x_pos = tbl[i].x;
            y_pos = tbl[i].y;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("vec_err", {31'd0, err}, {31'd0, tbl[i].exp_err});
            chk("vec_busy", {31'd0, busy}, {31'd0, tbl[i].exp_busy});
            chk("vec_cs_n", {31'd0, lcd_cs_n}, {31'd0, !tbl[i].exp_busy});
            chk("vec_own", {31'd0, lcd_own}, {31'd0, tbl[i].exp_busy});
            @(posedge clk); #1;
            chk("vec_err_one_cycle", {31'd0, err}, 0);
            chk("vec_busy_hold", {31'd0, busy}, {31'd0, tbl[i].exp_busy});
            reset_n = 1'b0;
            @(posedge clk); #1;
            reset_n = 1'b1;
        end

        // Full sprite with an ignored start re-pulse at pixel 100
        begin_transfer(9'd10, 9'd20);
        wait_falls(111);
        @(posedge clk); #1;
        x_pos = 9'd50; y_pos = 9'd60; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("restart_no_err", {31'd0, err}, 0);
        chk("restart_still_busy", {31'd0, busy}, 1);
        finish_checks();

        // Reset mid-pixel-stream aborts without done
        begin_transfer(9'd3, 9'd4);
        wait_falls(11 + 2000);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Far corner: xe=239, ye=319, reads stop at 4095
        begin_transfer(9'd176, 9'd256);
        finish_checks();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lt24_pic_streamer.md
LT24_PIC_STREAMER -- requirements
Module: lt24_pic_streamer

Interface
REQ-001 SHALL have parameter WR_LOW_CYC, default 2: cycles lcd_wr_n is held low per bus write (legal range 1..15).
REQ-002 SHALL have parameter WR_HIGH_CYC, default 2: cycles lcd_wr_n is held high after each low phase (legal range 1..15).
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: single-cycle request to stream one 64x64 sprite.
REQ-006 SHALL have port x_pos, input, 9: sprite left column (0..176).
REQ-007 SHALL have port y_pos, input, 9: sprite top row (0..256).
REQ-008 SHALL have ports busy (output, 1: transfer in progress), done (output, 1: completion pulse) and err (output, 1: rejected-start pulse).
REQ-009 SHALL have ports mem_address (output, 12), mem_chipselect (output, 1), mem_clken (output, 1), mem_write (output, 1), mem_writedata (output, 16), mem_byteenable (output, 2) and mem_readdata (input, 16): initiator for the pic_mem s2 port, which has read latency 1.
REQ-010 SHALL have ports lcd_cs_n, lcd_rs, lcd_rd_n and lcd_wr_n (each output, 1), lcd_data (output, 16) and lcd_own (output, 1): 8080 write bus plus the LT24 bus-mux select.

Function
REQ-011 SHALL tie mem_write=0, mem_writedata=0, mem_byteenable=2'b11 and lcd_rd_n=1 permanently.
REQ-012 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-013 SHALL reject start when x_pos>176 or y_pos>256: pulse err for 1 cycle, stay IDLE, leave busy low.
REQ-014 SHALL, on an accepted start, register x_pos and y_pos and assert busy, lcd_own and lcd_cs_n=0 from the next cycle until done.
REQ-015 SHALL issue exactly 4107 bus writes, in order (rs: 0=command, 1=data; parameters on lcd_data[7:0] with [15:8]=0):
- cmd 0x2A, then data xs[15:8], xs[7:0], xe[15:8], xe[7:0], where xe=xs+63;
- cmd 0x2B, then the same four bytes for ys/ye, where ye=ys+63;
- cmd 0x2C;
- data mem[0..4095], in ascending address order.
REQ-016 SHALL sequence each bus write as SETUP (1 cycle: rs/data valid, wr_n=1), then LOW (WR_LOW_CYC cycles, wr_n=0), then HIGH (WR_HIGH_CYC cycles, wr_n=1); lcd_rs and lcd_data SHALL be stable from SETUP through HIGH.
REQ-017 SHALL use FSM states IDLE -> CASET -> PASET -> RAMWR -> PIXELS -> FINISH -> IDLE.
REQ-018 SHALL prefetch pixel data: assert mem_chipselect=mem_clken=1 with the next address for one cycle during the preceding write's LOW phase, and capture mem_readdata on the following cycle into a holding register; no pixel write SETUP SHALL stall.
REQ-019 SHALL use a 12-bit pixel counter that terminates at 4095 with no wrap, and SHALL generate no memory read beyond address 4095.
REQ-020 SHALL, in FINISH, release lcd_cs_n=1 and lcd_own=0, pulse done for 1 cycle, drop busy in the same cycle, and return to IDLE.
REQ-021 SHALL hold mem_chipselect=mem_clken=0 whenever no read is in flight.

Reset
REQ-022 SHALL, while reset_n=0, asynchronously force: FSM=IDLE, counters=0, busy=done=err=0, lcd_own=0, lcd_cs_n=1, lcd_wr_n=1, lcd_rs=0, lcd_data=0, mem_address=0, mem_chipselect=0, mem_clken=0.
REQ-023 SHALL abort any transfer in progress on reset without emitting done; the next start SHALL restart from cmd 0x2A.

Structure
REQ-024 SHALL place the opcodes (0x2A, 0x2B, 0x2C), SPRITE_W=SPRITE_H=64, the x/y limits and the FSM state enum in package lt24_pkg.
REQ-025 SHALL implement the SETUP/LOW/HIGH timing in sub-module lt24_bus_writer (req/ack handshake: req sampled in its idle state, ack pulsed on the last HIGH cycle).

Verification
REQ-026 SHALL cover: start with x_pos=10, y_pos=20 -> writes 0x002A, 0x0000, 0x000A, 0x0000, 0x0049, 0x002B, 0x0000, 0x0014, 0x0000, 0x0053, 0x002C, then mem[i]=i^16'hA5A5 for i=0..4095, with done after the 4107th wr_n rising edge.
REQ-027 SHALL cover: with default parameters, each write takes 5 cycles, and done is asserted 20535+/-2 cycles after start with no gaps between writes.
REQ-028 SHALL cover: start with x_pos=177 -> err is a 1-cycle pulse, busy stays 0, and lcd_cs_n stays 1.
REQ-029 SHALL cover: start re-pulsed at pixel 100 -> it is ignored and the pixel sequence is unchanged.
REQ-030 SHALL cover: reset_n driven low at pixel 2000 -> all outputs take their reset values immediately and no done is emitted; a new start then begins at 0x2A.
REQ-031 SHALL cover: x_pos=176, y_pos=256 -> xe=239 and ye=319 are emitted, and no mem_address above 4095 is observed.
